// File: rtl/array_sort_check_param.sv
// Scans a contiguous array in an external register file and reports whether it is
// ordered (ascending/descending, strict/non-strict), plus the first inversion index.
module array_sort_check_param #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] length,
    input  logic              descending,
    input  logic              strict,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              sorted,
    output logic [ADDR_W-1:0] inv_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  len_q, len_d;
    logic               desc_q, desc_d;
    logic               strict_q, strict_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               done_q, done_d;
    logic               sorted_q, sorted_d;
    logic [ADDR_W-1:0]  inv_q, inv_d;

    logic cur_lt;
    logic cur_eq;
    logic inversion;
    logic last_pair;

    // Order test of the element being read (cur) against the previous one.
    always_comb begin
        if (SIGNED) begin
            cur_lt = $signed(rd_data) < $signed(prev_q);
        end else begin
            cur_lt = rd_data < prev_q;
        end
        cur_eq = (rd_data == prev_q);
        if (desc_q) begin
            inversion = strict_q ? !cur_lt : (!cur_lt && !cur_eq);
        end else begin
            inversion = strict_q ? (cur_lt || cur_eq) : cur_lt;
        end
        last_pair = (idx_q == len_q - ADDR_W'(1));
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        desc_d   = desc_q;
        strict_d = strict_q;
        idx_d    = idx_q;
        prev_d   = prev_q;
        done_d   = done_q;
        sorted_d = sorted_q;
        inv_d    = inv_q;
        rd_addr  = '0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    base_d   = base;
                    len_d    = length;
                    desc_d   = descending;
                    strict_d = strict;
                    idx_d    = '0;
                    done_d   = 1'b0;
                    sorted_d = 1'b0;
                    inv_d    = '0;
                    if (length <= ADDR_W'(1)) begin
                        done_d   = 1'b1;
                        sorted_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                rd_addr = base_q;
                prev_d  = rd_data;
                idx_d   = ADDR_W'(1);
                state_d = S_SCAN;
            end
            S_SCAN: begin
                // Address wraps modulo 2^ADDR_W by construction of the adder width.
                rd_addr = base_q + idx_q;
                if (inversion) begin
                    sorted_d = 1'b0;
                    inv_d    = idx_q - ADDR_W'(1);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    prev_d = rd_data;
                    if (last_pair) begin
                        sorted_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                // A held go must drop before another scan can be accepted.
                if (!go) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, with a synchronous
    // active-low reset that clears every register, including the prev data holder.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            desc_q   <= 1'b0;
            strict_q <= 1'b0;
            idx_q    <= '0;
            prev_q   <= '0;
            done_q   <= 1'b0;
            sorted_q <= 1'b0;
            inv_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            desc_q   <= desc_d;
            strict_q <= strict_d;
            idx_q    <= idx_d;
            prev_q   <= prev_d;
            done_q   <= done_d;
            sorted_q <= sorted_d;
            inv_q    <= inv_d;
        end
    end

    assign busy      = (state_q == S_LOAD) || (state_q == S_SCAN);
    assign done      = done_q;
    assign sorted    = sorted_q;
    assign inv_index = inv_q;

endmodule

// File: tb/tb_array_sort_check_param.sv
// Randomised and directed bench for array_sort_check_param; an unsigned and a signed
// instance share one register file and are both checked against a pair-wise model.
module tb_array_sort_check_param;

    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          go;
    logic [AW-1:0] base;
    logic [AW-1:0] length;
    logic          descending;
    logic          strict;
    logic [W-1:0]  mem [DEPTH];

    logic [AW-1:0] rd_addr_u, rd_addr_s, inv_index_u, inv_index_s;
    logic [W-1:0]  rd_data_u, rd_data_s;
    logic          busy_u, busy_s, done_u, done_s, sorted_u, sorted_s;

    int checks   = 0;
    int failures = 0;

    assign rd_data_u = mem[rd_addr_u];
    assign rd_data_s = mem[rd_addr_s];

    always #5 clock = ~clock;

    array_sort_check_param #(.WIDTH(W), .ADDR_W(AW), .SIGNED(1'b0)) u_dut (
        .clock(clock), .reset(reset), .go(go), .base(base), .length(length),
        .descending(descending), .strict(strict), .rd_addr(rd_addr_u),
        .rd_data(rd_data_u), .busy(busy_u), .done(done_u), .sorted(sorted_u),
        .inv_index(inv_index_u)
    );

    array_sort_check_param #(.WIDTH(W), .ADDR_W(AW), .SIGNED(1'b1)) u_dut_s (
        .clock(clock), .reset(reset), .go(go), .base(base), .length(length),
        .descending(descending), .strict(strict), .rd_addr(rd_addr_s),
        .rd_data(rd_data_s), .busy(busy_s), .done(done_s), .sorted(sorted_s),
        .inv_index(inv_index_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint elem(input int a, input bit sgn);
        logic [W-1:0] v;
        v = mem[a % DEPTH];
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    // Reference: walk neighbouring pairs, stop at the first one out of order.
    function automatic void model(input int b, input int l, input bit d, input bit s,
                                  input bit sgn, output bit srt, output int inv,
                                  output int lat, output int nrd);
        longint p, c;
        bit     bad;
        srt = 1'b1;
        inv = 0;
        nrd = (l <= 1) ? 0 : l;
        lat = (l <= 1) ? 1 : l + 1;
        for (int j = 0; j + 1 < l; j++) begin
            p   = elem(b + j, sgn);
            c   = elem(b + j + 1, sgn);
            bad = d ? (s ? (c >= p) : (c > p)) : (s ? (c <= p) : (c < p));
            if (bad) begin
                srt = 1'b0;
                inv = j;
                lat = j + 3;
                nrd = j + 2;
                break;
            end
        end
    endfunction

    task automatic run_scan(input string name, input int b, input int l, input bit d,
                            input bit s, input bit hold_go);
        bit e_srt [2];
        int e_inv [2], e_lat [2], e_nrd [2];
        bit got   [2];
        int nrd   [2], lat [2];
        logic [AW-1:0] addr_v [2];
        logic          busy_v [2], done_v [2];
        for (int u = 0; u < 2; u++) begin
            model(b, l, d, s, u[0], e_srt[u], e_inv[u], e_lat[u], e_nrd[u]);
            got[u] = 1'b0;
            nrd[u] = 0;
            lat[u] = 0;
        end
        @(posedge clock); #1;
        base       = AW'(b);
        length     = AW'(l);
        descending = d;
        strict     = s;
        go         = 1'b1;
        for (int k = 0; k < 40 && !(got[0] && got[1]); k++) begin
            @(posedge clock); #1;
            if (!hold_go) go = 1'b0;
            addr_v[0] = rd_addr_u; busy_v[0] = busy_u; done_v[0] = done_u;
            addr_v[1] = rd_addr_s; busy_v[1] = busy_s; done_v[1] = done_s;
            for (int u = 0; u < 2; u++) begin
                if (!got[u]) begin
                    if (busy_v[u]) begin
                        check($sformatf("%s rd_addr%0d[%0d]", name, u, nrd[u]),
                              32'(addr_v[u]), 32'((b + nrd[u]) % DEPTH));
                        nrd[u]++;
                    end
                    if (done_v[u]) begin
                        got[u] = 1'b1;
                        lat[u] = k + 1;
                    end
                end
            end
        end
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s done%0d", name, u), 32'(got[u]), 32'd1);
            check($sformatf("%s sorted%0d", name, u),
                  32'(u == 0 ? sorted_u : sorted_s), 32'(e_srt[u]));
            check($sformatf("%s inv_index%0d", name, u),
                  32'(u == 0 ? inv_index_u : inv_index_s), 32'(e_inv[u]));
            check($sformatf("%s latency%0d", name, u), 32'(lat[u]), 32'(e_lat[u]));
            check($sformatf("%s reads%0d", name, u), 32'(nrd[u]), 32'(e_nrd[u]));
        end
        if (hold_go) begin
            repeat (5) begin
                @(posedge clock); #1;
                check({name, " held busy"}, 32'(busy_u | busy_s), 32'd0);
                check({name, " held done"}, 32'(done_u & done_s), 32'd1);
            end
        end
        go = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check({name, " idle keeps done"}, 32'(done_u & done_s), 32'd1);
        check({name, " idle keeps sorted"}, 32'(sorted_u), 32'(e_srt[0]));
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"}, 32'({busy_u, busy_s}), 32'd0);
        check({name, " done"}, 32'({done_u, done_s}), 32'd0);
        check({name, " sorted"}, 32'({sorted_u, sorted_s}), 32'd0);
        check({name, " inv_index"}, 32'({inv_index_u, inv_index_s}), 32'd0);
        check({name, " rd_addr"}, 32'({rd_addr_u, rd_addr_s}), 32'd0);
    endtask

    initial begin
        int b, l;
        bit d, s;
        logic [W-1:0] v;
        reset = 1'b0; go = 1'b0; base = '0; length = '0;
        descending = 1'b0; strict = 1'b0;
        for (int k = 0; k < DEPTH; k++) mem[k] = W'(k);
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        run_scan("ramp", 11, 5, 1'b0, 1'b0, 1'b0);

        mem[2] = 1; mem[3] = 2; mem[4] = 3; mem[5] = 2; mem[6] = 5;
        run_scan("dip", 2, 5, 1'b0, 1'b0, 1'b0);

        mem[7] = 7; mem[8] = 8; mem[9] = 9; mem[10] = 6; mem[11] = 7;
        run_scan("prefix", 7, 3, 1'b0, 1'b0, 1'b0);

        mem[0] = 4; mem[1] = 4;
        run_scan("eq_strict", 0, 2, 1'b0, 1'b1, 1'b0);
        run_scan("eq_loose", 0, 2, 1'b0, 1'b0, 1'b0);

        mem[20] = 9; mem[21] = 7; mem[22] = 7; mem[23] = 1;
        run_scan("desc", 20, 4, 1'b1, 1'b0, 1'b0);
        run_scan("desc_strict", 20, 4, 1'b1, 1'b1, 1'b0);

        mem[0] = 32'hFFFF_FFFF; mem[1] = 0;
        run_scan("neg_one", 0, 2, 1'b0, 1'b0, 1'b0);

        run_scan("len0", 5, 0, 1'b0, 1'b0, 1'b0);
        run_scan("len1", 5, 1, 1'b0, 1'b1, 1'b0);

        mem[31] = 3; mem[0] = 4; mem[1] = 5;
        run_scan("wrap", 31, 3, 1'b0, 1'b0, 1'b0);

        run_scan("go_held", 31, 3, 1'b0, 1'b0, 1'b1);

        // Abort a long scan with reset while go is also asserted.
        for (int k = 0; k < 8; k++) mem[k] = W'(k);
        @(posedge clock); #1;
        base = '0; length = AW'(8); descending = 1'b0; strict = 1'b0; go = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("pre-reset busy", 32'(busy_u & busy_s), 32'd1);
        reset = 1'b0;
        @(posedge clock); #1;
        check_all_zero("mid-scan reset");
        reset = 1'b1; go = 1'b0;
        @(posedge clock); #1;
        check("post-reset idle", 32'(busy_u | busy_s), 32'd0);

        for (int it = 0; it < 30; it++) begin
            b = int'($urandom_range(0, DEPTH - 1));
            l = int'($urandom_range(0, DEPTH - 1));
            d = 1'($urandom);
            s = 1'($urandom);
            v = $urandom;
            for (int k = 0; k < DEPTH; k++) begin
                if (it % 2 == 0) begin
                    mem[(b + k) % DEPTH] = v;
                    v = d ? v - W'($urandom_range(0, 2)) : v + W'($urandom_range(0, 2));
                end else begin
                    v = W'($urandom_range(0, 7));
                    mem[(b + k) % DEPTH] = 1'($urandom) ? -v : v;
                end
            end
            run_scan($sformatf("rand%0d", it), b, l, d, s, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/array_sort_check_param.md
# array_sort_check_param

Parametrised successor to the lab array sort checker: a single-FSM engine that scans a contiguous array in an external register file and reports whether it is ordered. It adds configurable data/address width, signed or unsigned compare, runtime-selectable ascending/descending and strict/non-strict ordering, and the index of the first inversion. The block drives the register file read address, consumes the read data, and sits beside the register file as its only reader during a scan.

## Interface

Parameters:
- WIDTH, 32, element width in bits
- ADDR_W, 5, register file address width; array length is also ADDR_W bits
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock
- go  in  1  start request, level-sensitive
- base  in  ADDR_W  address of element 0
- length  in  ADDR_W  number of elements
- descending  in  1  0 = ascending order required, 1 = descending
- strict  in  1  1 = equal neighbours count as an inversion
- rd_addr  out  ADDR_W  register file read address
- rd_data  in  WIDTH  register file read data, combinational from rd_addr (same cycle)
- busy  out  1  scan in progress
- done  out  1  result valid
- sorted  out  1  1 = no inversion found
- inv_index  out  ADDR_W  array index j of first inversion pair (j, j+1)

## Operation

- States: IDLE, LOAD, SCAN, DONE. Registers: base_r, len_r, desc_r, strict_r, index i (ADDR_W), prev (WIDTH).
- IDLE: if go=1, latch base/length/descending/strict, clear done/sorted/inv_index. If length<=1 go to DONE with sorted=1, else to LOAD.
- LOAD: rd_addr=base_r; prev<=rd_data; i<=1; to SCAN.
- SCAN: rd_addr=base_r+i (mod 2^ADDR_W, wrap-around permitted); compare cur=rd_data against prev.
- Inversion: asc non-strict cur<prev; asc strict cur<=prev; desc non-strict cur>prev; desc strict cur>=prev.
- On inversion: sorted<=0, inv_index<=i-1, done<=1, to DONE.
- No inversion: prev<=cur; if i==len_r-1 then sorted<=1, done<=1, to DONE; else i<=i+1.
- DONE: done, sorted, inv_index held. go=0 moves to IDLE; results stay held in IDLE until the next accepted go. go held high in DONE does not restart.
- Inputs other than rd_data are ignored outside IDLE; mid-scan changes have no effect.
- Reads never address beyond base_r+len_r-1.
- rd_addr = base_r+i in LOAD/SCAN, 0 in IDLE/DONE.

## Timing

- Reset (reset=0 at an edge): state IDLE; busy=0, done=0, sorted=0, inv_index=0, rd_addr=0, internal registers 0. Reset overrides go and aborts any scan the same edge.
- busy=1 exactly in LOAD and SCAN.
- Edge E0 accepts go. Latency to done=1, counted in edges after E0 inclusive:
  - length 0 or 1: 1 edge
  - sorted, length L>=2: L+1 edges
  - first inversion at pair (j, j+1): j+3 edges
- done rises on the same edge sorted/inv_index become valid; never glitches mid-scan.
- One register file read per cycle. No read in IDLE/DONE is required to be meaningful.

## Test plan

- Registers r[k]=k; base=11, length=5, ascending, non-strict -> sorted=1, inv_index=0, done 6 edges after go accepted; rd_addr sequence 11..15.
- r[2..6]=1,2,3,2,5; base=2, length=5 -> sorted=0, inv_index=2, done 5 edges after go; r[6] never read.
- r[7..11]=7,8,9,6,7; base=7, length=3 -> sorted=1; rd_addr never exceeds 9.
- Values 4,4 with strict=1 -> sorted=0, inv_index=0; strict=0 -> sorted=1. Values 9,7,7,1 with descending=1, strict=0 -> sorted=1. SIGNED=1: -1,0 ascending -> sorted=1.
- length=0 and length=1 -> done after 1 edge, sorted=1, busy never 1. base=31, length=3 -> rd_addr 31,0,1.
- reset=0 during SCAN -> next edge all outputs 0, state IDLE. go held high through DONE -> no second scan until go drops and rises again.
